// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } hz_state_t;

  localparam int REG_AW_DEF = 4;   // default register-address width
  localparam int CNT_W      = 16;  // performance counter width

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module hazard_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_reg;

  // Count qualifying cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != {WIDTH{1'b1}})) begin
      cnt_reg <= cnt_reg + WIDTH'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: controls PC / IF-ID advance,
// hold and flush, and ID/EX bubble injection for load-use hazards, taken
// branches and data-memory wait states.
// Optional macro HAZARD_PERF_EN builds the stall / flush performance counters;
// without it both counter outputs read 0.
// rst is asynchronous and active-low.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_we,
  output logic              if_id_we,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              mem_timeout,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // fl_cnt holds the FLUSH-state cycles still owed, counting the current one.
  // The branch cycle itself is the first flush cycle, so FLUSH lasts
  // FLUSH_CYCLES-1 cycles and the total flush window is FLUSH_CYCLES.
  localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int BW   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FL_W-1:0] FL_LOAD  = FL_W'(FLUSH_CYCLES - 1);
  localparam logic [BW-1:0]   BUSY_MAX = BW'(MEM_TIMEOUT);

  hz_state_t        state_reg, state_next;
  logic [FL_W-1:0]  fl_cnt_reg, fl_cnt_next;
  logic [BW-1:0]    busy_cnt_reg, busy_cnt_next;
  logic             pend_reg, pend_next;
  logic             timeout_reg, timeout_next;

  logic             pc_we_comb, if_id_we_comb, flush_comb, bubble_comb;
  logic             load_use, branch_go;

  assign load_use = ex_mem_read &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) |
                     (id_use_rs2 & (id_rs2 == ex_rd)));

  // Next-state and output decode; priority is mem_busy > branch > load-use.
  always_comb begin
    state_next    = state_reg;
    fl_cnt_next   = fl_cnt_reg;
    busy_cnt_next = busy_cnt_reg;
    pend_next     = pend_reg;
    pc_we_comb    = 1'b1;
    if_id_we_comb = 1'b1;
    flush_comb    = 1'b0;
    bubble_comb   = 1'b0;
    branch_go     = 1'b0;

    unique case (state_reg)
      RUN, LOAD_STALL: begin
        if (mem_busy) begin
          pc_we_comb    = 1'b0;
          if_id_we_comb = 1'b0;
          pend_next     = pend_reg | branch_taken;
          busy_cnt_next = BW'(1);
          state_next    = MEM_WAIT;
        end else if (branch_taken) begin
          branch_go = 1'b1;
        end else if (load_use && (state_reg == RUN)) begin
          // The stall lasts one cycle; in LOAD_STALL the load has moved on.
          pc_we_comb    = 1'b0;
          if_id_we_comb = 1'b0;
          bubble_comb   = 1'b1;
          state_next    = LOAD_STALL;
        end else begin
          state_next = RUN;
        end
      end

      FLUSH: begin
        if (mem_busy) begin
          // Flush is interrupted; replay a full flush once memory frees up.
          pc_we_comb    = 1'b0;
          if_id_we_comb = 1'b0;
          pend_next     = 1'b1;
          busy_cnt_next = BW'(1);
          fl_cnt_next   = '0;
          state_next    = MEM_WAIT;
        end else begin
          flush_comb = 1'b1;
          if (branch_taken) begin
            fl_cnt_next = FL_LOAD;
          end else if (fl_cnt_reg <= FL_W'(1)) begin
            fl_cnt_next = '0;
            state_next  = RUN;
          end else begin
            fl_cnt_next = fl_cnt_reg - FL_W'(1);
          end
        end
      end

      MEM_WAIT: begin
        if (mem_busy) begin
          pc_we_comb    = 1'b0;
          if_id_we_comb = 1'b0;
          pend_next     = pend_reg | branch_taken;
          busy_cnt_next = (busy_cnt_reg == BUSY_MAX) ? BUSY_MAX
                                                     : busy_cnt_reg + BW'(1);
        end else begin
          busy_cnt_next = '0;
          pend_next     = 1'b0;
          if (pend_reg || branch_taken) begin
            branch_go = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
    endcase

    // Shared taken-branch action: flush IF/ID, bubble ID/EX, start the window.
    if (branch_go) begin
      pc_we_comb  = 1'b1;
      flush_comb  = 1'b1;
      bubble_comb = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        fl_cnt_next = FL_LOAD;
        state_next  = FLUSH;
      end else begin
        state_next = RUN;
      end
    end
  end

  // Sticky timeout flag, raised on the cycle the busy run reaches the limit.
  always_comb begin
    timeout_next = timeout_reg;
    if (mem_busy && (busy_cnt_next == BUSY_MAX)) begin
      timeout_next = 1'b1;
    end
  end

  // State, flush/busy counters and pending-branch register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= RUN;
      fl_cnt_reg   <= '0;
      busy_cnt_reg <= '0;
      pend_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fl_cnt_reg   <= fl_cnt_next;
      busy_cnt_reg <= busy_cnt_next;
      pend_reg     <= pend_next;
      timeout_reg  <= timeout_next;
    end
  end

  // Pipeline controls are forced idle while reset is asserted.
  assign pc_we        = rst & pc_we_comb;
  assign if_id_we     = rst & if_id_we_comb;
  assign if_id_flush  = rst & flush_comb;
  assign id_ex_bubble = rst & bubble_comb;
  assign mem_timeout  = timeout_reg;
  assign state_o      = state_reg;

`ifdef HAZARD_PERF_EN
  logic stall_inc, flush_inc;

  assign stall_inc = (state_next == LOAD_STALL) | (state_reg == MEM_WAIT);
  assign flush_inc = if_id_flush;

  hazard_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  hazard_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
// Counter expectations follow the HAZARD_PERF_EN macro of the build.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  localparam int RAW = 4;
  localparam int FC  = 2;
  localparam int MT  = 15;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [RAW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic           id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0;
  logic           branch_taken = 0, mem_busy = 0;
  logic           pc_we, if_id_we, if_id_flush, id_ex_bubble, mem_timeout;
  logic [1:0]     state_o;
  logic [15:0]    stall_cnt, flush_cnt;
  logic [3:0]     outs;

  assign outs = {pc_we, if_id_we, if_id_flush, id_ex_bubble};

  pipeline_hazard_ctrl #(.REG_AW(RAW), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .mem_timeout(mem_timeout), .state_o(state_o),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Behavioural model: flush cycles still owed, memory-wait flag, pending
  // branch, whether last cycle was a load-use stall, busy run length.
  int m_flush_left, m_busy_run, m_stall_n, m_flush_n;
  bit m_wait, m_pend, m_stalled, m_timeout;
  int n_flush_left, n_busy_run, n_stall_n, n_flush_n;
  bit n_wait, n_pend, n_stalled, n_timeout;
  logic [3:0] exp_out;

  task automatic model_reset();
    m_flush_left = 0; m_busy_run = 0; m_stall_n = 0; m_flush_n = 0;
    m_wait = 0; m_pend = 0; m_stalled = 0; m_timeout = 0;
  endtask

  task automatic model_eval();
    bit lu, do_br;
    lu = ex_mem_read && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    n_flush_left = m_flush_left; n_busy_run = m_busy_run; n_stall_n = m_stall_n;
    n_flush_n = m_flush_n; n_wait = m_wait; n_pend = m_pend; n_timeout = m_timeout;
    n_stalled = 0;
    do_br = 0;
    exp_out = 4'b1100;
    if (m_wait) begin
      if (mem_busy) begin
        exp_out = 4'b0000;
        n_pend = m_pend | branch_taken;
        n_busy_run = (m_busy_run + 1 > MT) ? MT : m_busy_run + 1;
      end else begin
        n_wait = 0; n_busy_run = 0; n_pend = 0;
        do_br = m_pend | branch_taken;
      end
    end else if (mem_busy) begin
      exp_out = 4'b0000;
      n_wait = 1; n_busy_run = 1; n_flush_left = 0;
      n_pend = (m_flush_left > 0) ? 1'b1 : branch_taken;
    end else if (m_flush_left > 0) begin
      exp_out = 4'b1110;
      n_flush_left = branch_taken ? FC - 1 : m_flush_left - 1;
    end else if (branch_taken) begin
      do_br = 1;
    end else if (lu && !m_stalled) begin
      exp_out = 4'b0001;
      n_stalled = 1;
    end
    if (do_br) begin
      exp_out = 4'b1111;
      n_flush_left = FC - 1;
    end
    if (mem_busy && n_busy_run >= MT) n_timeout = 1;
    if ((n_stalled || m_wait) && m_stall_n < 65535) n_stall_n = m_stall_n + 1;
    if (exp_out[1] && m_flush_n < 65535) n_flush_n = m_flush_n + 1;
  endtask

  task automatic set_in(input logic [RAW-1:0] rs1, input logic [RAW-1:0] rs2,
                        input logic u1, input logic u2, input logic mr,
                        input logic [RAW-1:0] rd, input logic bt, input logic mb);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_mem_read = mr; ex_rd = rd; branch_taken = bt; mem_busy = mb;
    #2;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_flush_left = n_flush_left; m_busy_run = n_busy_run; m_stall_n = n_stall_n;
      m_flush_n = n_flush_n; m_wait = n_wait; m_pend = n_pend;
      m_stalled = n_stalled; m_timeout = n_timeout;
    end
    #1;
    $display("cyc t=%0t mb=%b bt=%b mr=%b out=%b tmo=%b st=%0d stall=%0d flush=%0d",
             $time, mem_busy, branch_taken, ex_mem_read, outs, mem_timeout,
             state_o, stall_cnt, flush_cnt);
  endtask

  task automatic apply_reset();
    rst = 0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_mem_read = 0; branch_taken = 0; mem_busy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 0; branch_taken = 1; mem_busy = 0;
    #1;
    checks++; if (outs !== 4'b0000) $display("FAIL reset_outs: got %b want 0000", outs); else passed++;
    checks++; if (state_o !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_o); else passed++;
    checks++; if (mem_timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", mem_timeout); else passed++;
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0)
      $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt); else passed++;
    @(posedge clk); #1 rst = 1;
    model_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (outs !== 4'b1100) $display("FAIL reset_release_defaults: got %b want 1100", outs); else passed++;
    tick();
  endtask

  task automatic test_load_use();
    set_in(4'd3, 4'd0, 1, 0, 1, 4'd3, 0, 0);
    checks++; if (outs !== 4'b0001) $display("FAIL load_use_stall: got %b want 0001", outs); else passed++;
    tick();
    set_in(4'd3, 4'd0, 1, 0, 1, 4'd3, 0, 0);
    checks++; if (outs !== 4'b1100) $display("FAIL load_use_masked: got %b want 1100", outs); else passed++;
    tick();
    set_in(4'd3, 4'd0, 0, 0, 1, 4'd3, 0, 0);
    checks++; if (outs !== 4'b1100) $display("FAIL load_use_unused_reg: got %b want 1100", outs); else passed++;
    tick();
    set_in(4'd3, 4'd0, 1, 0, 0, 4'd3, 0, 0);
    checks++; if (outs !== 4'b1100) $display("FAIL load_use_not_load: got %b want 1100", outs); else passed++;
    tick();
  endtask

  task automatic test_branch();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    checks++; if (outs !== 4'b1111) $display("FAIL branch_first: got %b want 1111", outs); else passed++;
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (outs !== 4'b1110) $display("FAIL branch_second: got %b want 1110", outs); else passed++;
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (outs !== 4'b1100) $display("FAIL branch_done: got %b want 1100", outs); else passed++;
    tick();
    checks++; if (stall_cnt !== (PERF ? 16'd1 : 16'd0))
      $display("FAIL perf_stall_cnt: got %0d want %0d", stall_cnt, PERF ? 1 : 0); else passed++;
    checks++; if (flush_cnt !== (PERF ? 16'd2 : 16'd0))
      $display("FAIL perf_flush_cnt: got %0d want %0d", flush_cnt, PERF ? 2 : 0); else passed++;
  endtask

  task automatic test_branch_under_busy();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, (i == 1), 1);
      checks++; if (outs !== 4'b0000) $display("FAIL busy_hold_%0d: got %b want 0000", i, outs); else passed++;
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (outs !== 4'b1111) $display("FAIL busy_pending_flush: got %b want 1111", outs); else passed++;
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (outs !== 4'b1110) $display("FAIL busy_flush_second: got %b want 1110", outs); else passed++;
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (outs !== 4'b1100) $display("FAIL busy_flush_done: got %b want 1100", outs); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_flush();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (outs !== 4'b1110) $display("FAIL midflush_in_flush: got %b want 1110", outs); else passed++;
    rst = 0;
    #1;
    checks++; if (outs !== 4'b0000) $display("FAIL midflush_reset_outs: got %b want 0000", outs); else passed++;
    checks++; if (state_o !== 2'd0) $display("FAIL midflush_reset_state: got %0d want 0", state_o); else passed++;
    model_reset();
    @(posedge clk); #1 rst = 1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (outs !== 4'b1100) $display("FAIL midflush_no_residue: got %b want 1100", outs); else passed++;
    tick();
  endtask

  task automatic test_timeout();
    for (int i = 1; i <= MT; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      checks++; if (mem_timeout !== (i >= MT))
        $display("FAIL timeout_cycle_%0d: got %b want %b", i, mem_timeout, (i >= MT)); else passed++;
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (outs !== 4'b1100) $display("FAIL timeout_release_outs: got %b want 1100", outs); else passed++;
    tick();
    checks++; if (mem_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", mem_timeout); else passed++;
  endtask

  task automatic test_random();
    logic mb;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      mb = (c >= 200 && c < 218) ? 1'b1 : ($urandom_range(0, 99) < 20);
      set_in(RAW'($urandom_range(0, 3)), RAW'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 99) < 40), RAW'($urandom_range(0, 3)),
             ($urandom_range(0, 99) < 15), mb);
      checks++; if (outs !== exp_out)
        $display("FAIL rand_outs_%0d: got %b want %b", c, outs, exp_out); else passed++;
      tick();
      checks++; if (mem_timeout !== m_timeout)
        $display("FAIL rand_timeout_%0d: got %b want %b", c, mem_timeout, m_timeout); else passed++;
      checks++; if (stall_cnt !== (PERF ? 16'(m_stall_n) : 16'd0) ||
                    flush_cnt !== (PERF ? 16'(m_flush_n) : 16'd0))
        $display("FAIL rand_counters_%0d: got %0d/%0d want %0d/%0d", c, stall_cnt, flush_cnt,
                 PERF ? m_stall_n : 0, PERF ? m_flush_n : 0); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_branch_under_busy();
    test_reset_mid_flush();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
